// File: rtl/bram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : bram_arbiter_if
// Description : Requester-side bundle of the two-port BRAM arbiter.
//               master : seen from the requesters (drive req/addr/din/we)
//               slave  : seen from the arbiter (drives gnt/rdata/rvalid)
// Signals     : reqN, gntN, addrN[AW], dinN[WIDTH], weN   (N = 0,1)
//               rdata[WIDTH] shared read data, rvalidN per-requester valid
// Revision    : 1.0 - initial release
// ============================================================================
interface bram_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 8
);
  logic             req0;
  logic             req1;
  logic             gnt0;
  logic             gnt1;
  logic [AW-1:0]    addr0;
  logic [AW-1:0]    addr1;
  logic [WIDTH-1:0] din0;
  logic [WIDTH-1:0] din1;
  logic             we0;
  logic             we1;
  logic [WIDTH-1:0] rdata;
  logic             rvalid0;
  logic             rvalid1;

  modport master (
    output req0, req1, addr0, addr1, din0, din1, we0, we1,
    input  gnt0, gnt1, rdata, rvalid0, rvalid1
  );

  modport slave (
    input  req0, req1, addr0, addr1, din0, din1, we0, we1,
    output gnt0, gnt1, rdata, rvalid0, rvalid1
  );
endinterface
`default_nettype wire

// File: rtl/bram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bram_arbiter
// Description : Shares one single-port, 1-cycle-latency BRAM between two
//               requesters. Ownership is held until released, contention is
//               resolved round-robin, and an optional hold limit lets a
//               waiting requester preempt the owner. Each requester addresses
//               its own window via a per-requester base offset.
// Ports       : clk        clock
//               rst_n      asynchronous reset, active low
//               bus        requester bundle (bram_arbiter_if.slave)
//               mem_addr   BRAM address
//               mem_din    BRAM write data
//               mem_we     BRAM write enable
//               mem_dout   BRAM read data (returned unmodified on bus.rdata)
// Revision    : 1.0 - initial release
// ============================================================================
module bram_arbiter #(
  parameter int WIDTH    = 8,
  parameter int AW       = 8,
  parameter int BASE0    = 0,
  parameter int BASE1    = 128,
  parameter int MAX_HOLD = 0
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  bram_arbiter_if.slave         bus,
  output logic [AW-1:0]         mem_addr,
  output logic [WIDTH-1:0]      mem_din,
  output logic                  mem_we,
  input  wire logic [WIDTH-1:0] mem_dout
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  localparam int         HW         = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_SAT = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam bit         PREEMPT_EN = (MAX_HOLD > 0);
  localparam logic [AW-1:0] OFS0    = AW'(BASE0);
  localparam logic [AW-1:0] OFS1    = AW'(BASE1);

  logic [1:0]    state, state_nxt;
  logic          last, last_nxt;     // requester served most recently
  logic [HW-1:0] hold_cnt, hold_nxt;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last        <= 1'b1;
      hold_cnt    <= '0;
      bus.rvalid0 <= 1'b0;
      bus.rvalid1 <= 1'b0;
    end else begin
      state       <= state_nxt;
      last        <= last_nxt;
      hold_cnt    <= hold_nxt;
      bus.rvalid0 <= bus.gnt0 & ~bus.we0;
      bus.rvalid1 <= bus.gnt1 & ~bus.we1;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (bus.req0 && bus.req1) state_nxt = last ? OWN0 : OWN1;
        else if (bus.req0)        state_nxt = OWN0;
        else if (bus.req1)        state_nxt = OWN1;
      end
      OWN0: begin
        if (!bus.req0) begin
          state_nxt = bus.req1 ? OWN1 : IDLE;
          last_nxt  = 1'b0;
        end else if (PREEMPT_EN && bus.req1 && hold_cnt == HOLD_SAT) begin
          state_nxt = OWN1;
          last_nxt  = 1'b0;
        end
      end
      OWN1: begin
        if (!bus.req1) begin
          state_nxt = bus.req0 ? OWN0 : IDLE;
          last_nxt  = 1'b1;
        end else if (PREEMPT_EN && bus.req0 && hold_cnt == HOLD_SAT) begin
          state_nxt = OWN0;
          last_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Hold counter restarts on any ownership change and saturates so a
    // long-idle owner is preempted on the very next edge once the other waits.
    if (state_nxt != state)
      hold_nxt = '0;
    else if (state != IDLE && hold_cnt != HOLD_SAT)
      hold_nxt = hold_cnt + 1'b1;
    else
      hold_nxt = hold_cnt;
  end

  // Output logic: grants and BRAM datapath decoded from state
  always_comb begin
    bus.gnt0 = (state == OWN0);
    bus.gnt1 = (state == OWN1);
    mem_addr = '0;
    mem_din  = '0;
    mem_we   = 1'b0;
    case (state)
      OWN0: begin
        mem_addr = bus.addr0 + OFS0;   // wraps modulo 2**AW
        mem_din  = bus.din0;
        mem_we   = bus.we0;
      end
      OWN1: begin
        mem_addr = bus.addr1 + OFS1;
        mem_din  = bus.din1;
        mem_we   = bus.we1;
      end
      default: ;
    endcase
  end

  assign bus.rdata = mem_dout;

endmodule
`default_nettype wire

// File: tb/tb_bram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bram_arbiter
// Description : Directed self-checking bench. dut_a runs with no hold limit,
//               dut_b with MAX_HOLD=4. Each drives a behavioural BRAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  bram_arbiter_if #(.WIDTH(8), .AW(8)) a ();
  bram_arbiter_if #(.WIDTH(8), .AW(8)) b ();

  logic [7:0] ma_addr, ma_din, ma_dout, mb_addr, mb_din, mb_dout;
  logic       ma_we, mb_we;
  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];

  bram_arbiter #(.WIDTH(8), .AW(8), .BASE0(0), .BASE1(128), .MAX_HOLD(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(a),
    .mem_addr(ma_addr), .mem_din(ma_din), .mem_we(ma_we), .mem_dout(ma_dout)
  );

  bram_arbiter #(.WIDTH(8), .AW(8), .BASE0(0), .BASE1(128), .MAX_HOLD(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(b),
    .mem_addr(mb_addr), .mem_din(mb_din), .mem_we(mb_we), .mem_dout(mb_dout)
  );

  always @(posedge clk) begin
    if (ma_we) mem_a[ma_addr] <= ma_din;
    ma_dout <= mem_a[ma_addr];
    if (mb_we) mem_b[mb_addr] <= mb_din;
    mb_dout <= mem_b[mb_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    total++; if (a.gnt0 !== 1'b0)    begin bad++; $display("FAIL rst_gnt0 got=%b exp=0", a.gnt0); end
    total++; if (a.gnt1 !== 1'b0)    begin bad++; $display("FAIL rst_gnt1 got=%b exp=0", a.gnt1); end
    total++; if (a.rvalid0 !== 1'b0) begin bad++; $display("FAIL rst_rvalid0 got=%b exp=0", a.rvalid0); end
    total++; if (a.rvalid1 !== 1'b0) begin bad++; $display("FAIL rst_rvalid1 got=%b exp=0", a.rvalid1); end
    total++; if (ma_we !== 1'b0)     begin bad++; $display("FAIL rst_mem_we got=%b exp=0", ma_we); end
    total++; if (ma_addr !== 8'd0)   begin bad++; $display("FAIL rst_mem_addr got=%0d exp=0", ma_addr); end
    total++; if (b.gnt0 !== 1'b0)    begin bad++; $display("FAIL rst_b_gnt0 got=%b exp=0", b.gnt0); end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    tick();
    a.req0 = 1'b1;
    #1;
    total++; if (a.gnt0 !== 1'b0) begin bad++; $display("FAIL wr_latency got=%b exp=0", a.gnt0); end
    tick();
    total++; if (a.gnt0 !== 1'b1) begin bad++; $display("FAIL wr_grant got=%b exp=1", a.gnt0); end
    a.addr0 = 8'd5; a.din0 = 8'hA5; a.we0 = 1'b1;
    #1;
    total++; if (ma_addr !== 8'd5)  begin bad++; $display("FAIL wr_addr got=%0d exp=5", ma_addr); end
    total++; if (ma_we !== 1'b1)    begin bad++; $display("FAIL wr_we got=%b exp=1", ma_we); end
    total++; if (ma_din !== 8'hA5)  begin bad++; $display("FAIL wr_din got=%h exp=a5", ma_din); end
    tick();
    a.we0 = 1'b0;
    #1;
    total++; if (ma_we !== 1'b0) begin bad++; $display("FAIL rd_we got=%b exp=0", ma_we); end
    tick();
    total++; if (a.rvalid0 !== 1'b1) begin bad++; $display("FAIL rd_rvalid0 got=%b exp=1", a.rvalid0); end
    total++; if (a.rdata !== 8'hA5)  begin bad++; $display("FAIL rd_rdata got=%h exp=a5", a.rdata); end
    a.req0 = 1'b0;   // last owned cycle is still a read
    tick();
    total++; if (a.gnt0 !== 1'b0)    begin bad++; $display("FAIL rel_gnt0 got=%b exp=0", a.gnt0); end
    total++; if (a.rvalid0 !== 1'b1) begin bad++; $display("FAIL rel_rvalid0 got=%b exp=1", a.rvalid0); end
    tick();
    total++; if (a.rvalid0 !== 1'b0) begin bad++; $display("FAIL idle_rvalid0 got=%b exp=0", a.rvalid0); end
  endtask

  task automatic test_window1();
    a.req1 = 1'b1;
    tick();
    total++; if (a.gnt1 !== 1'b1) begin bad++; $display("FAIL w1_grant got=%b exp=1", a.gnt1); end
    a.addr1 = 8'd5; a.din1 = 8'h3C; a.we1 = 1'b1;
    #1;
    total++; if (ma_addr !== 8'd133) begin bad++; $display("FAIL w1_addr got=%0d exp=133", ma_addr); end
    total++; if (ma_we !== 1'b1)     begin bad++; $display("FAIL w1_we got=%b exp=1", ma_we); end
    tick();
    a.addr1 = 8'd200; a.we1 = 1'b0;
    #1;
    total++; if (ma_addr !== 8'd72) begin bad++; $display("FAIL w1_wrap got=%0d exp=72", ma_addr); end
    a.req1 = 1'b0;
    tick();
    a.we1 = 1'b1; a.addr1 = 8'd9;
    #1;
    total++; if (ma_we !== 1'b0)   begin bad++; $display("FAIL w1_ungranted_we got=%b exp=0", ma_we); end
    total++; if (ma_addr !== 8'd0) begin bad++; $display("FAIL w1_idle_addr got=%0d exp=0", ma_addr); end
    a.we1 = 1'b0;
    a.req0 = 1'b1;
    tick();
    total++; if (a.gnt0 !== 1'b1) begin bad++; $display("FAIL w1_rd_grant got=%b exp=1", a.gnt0); end
    a.addr0 = 8'd133;
    tick();
    total++; if (a.rdata !== 8'h3C) begin bad++; $display("FAIL w1_readback got=%h exp=3c", a.rdata); end
    a.req0 = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_round_robin();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    a.req0 = 1'b1; a.req1 = 1'b1;
    tick();
    total++; if (a.gnt0 !== 1'b1) begin bad++; $display("FAIL rr_first_gnt0 got=%b exp=1", a.gnt0); end
    total++; if (a.gnt1 !== 1'b0) begin bad++; $display("FAIL rr_first_gnt1 got=%b exp=0", a.gnt1); end
    repeat (6) tick();
    total++; if (a.gnt0 !== 1'b1) begin bad++; $display("FAIL rr_hold got=%b exp=1", a.gnt0); end
    a.req0 = 1'b0;
    tick();
    total++; if (a.gnt1 !== 1'b1) begin bad++; $display("FAIL rr_handover got=%b exp=1", a.gnt1); end
    a.req1 = 1'b0;
    tick();
    total++; if (a.gnt1 !== 1'b0) begin bad++; $display("FAIL rr_idle got=%b exp=0", a.gnt1); end
    a.req0 = 1'b1; a.req1 = 1'b1;
    tick();
    total++; if (a.gnt0 !== 1'b1) begin bad++; $display("FAIL rr_after1 got=%b exp=1", a.gnt0); end
    a.req0 = 1'b0; a.req1 = 1'b0;
    tick();
    a.req0 = 1'b1; a.req1 = 1'b1;
    tick();
    total++; if (a.gnt1 !== 1'b1) begin bad++; $display("FAIL rr_after0 got=%b exp=1", a.gnt1); end
    a.req0 = 1'b0; a.req1 = 1'b0;
    tick();
  endtask

  task automatic test_preempt();
    b.req0 = 1'b1;
    tick();
    total++; if (b.gnt0 !== 1'b1) begin bad++; $display("FAIL pre_grant got=%b exp=1", b.gnt0); end
    b.req1 = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      tick();
      total++; if (b.gnt0 !== 1'b1) begin bad++; $display("FAIL pre_own_cycle%0d got=%b exp=1", i, b.gnt0); end
    end
    tick();
    total++; if (b.gnt1 !== 1'b1) begin bad++; $display("FAIL pre_switch_gnt1 got=%b exp=1", b.gnt1); end
    total++; if (b.gnt0 !== 1'b0) begin bad++; $display("FAIL pre_switch_gnt0 got=%b exp=0", b.gnt0); end
    tick();
    total++; if (b.gnt1 !== 1'b1) begin bad++; $display("FAIL pre_own1 got=%b exp=1", b.gnt1); end
    b.req1 = 1'b0;
    tick();
    total++; if (b.gnt0 !== 1'b1) begin bad++; $display("FAIL pre_regain got=%b exp=1", b.gnt0); end
    b.req0 = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    a.req1 = 1'b1;
    tick();
    total++; if (a.gnt1 !== 1'b1) begin bad++; $display("FAIL rm_grant got=%b exp=1", a.gnt1); end
    a.addr1 = 8'd3; a.din1 = 8'h11; a.we1 = 1'b1;
    tick();
    a.we1 = 1'b0;
    tick();
    total++; if (a.rvalid1 !== 1'b1) begin bad++; $display("FAIL rm_rvalid1 got=%b exp=1", a.rvalid1); end
    a.din1 = 8'h77; a.we1 = 1'b1;
    #1;
    total++; if (ma_we !== 1'b1) begin bad++; $display("FAIL rm_we_pre got=%b exp=1", ma_we); end
    rst_n = 1'b0;
    #1;
    total++; if (ma_we !== 1'b0)     begin bad++; $display("FAIL rm_we_async got=%b exp=0", ma_we); end
    total++; if (a.gnt1 !== 1'b0)    begin bad++; $display("FAIL rm_gnt1_async got=%b exp=0", a.gnt1); end
    total++; if (a.rvalid1 !== 1'b0) begin bad++; $display("FAIL rm_rvalid1_async got=%b exp=0", a.rvalid1); end
    a.req1 = 1'b0; a.we1 = 1'b0;
    tick();
    rst_n = 1'b1;
    a.req0 = 1'b1; a.req1 = 1'b1;
    tick();
    total++; if (a.gnt0 !== 1'b1) begin bad++; $display("FAIL rm_resume_gnt0 got=%b exp=1", a.gnt0); end
    total++; if (a.gnt1 !== 1'b0) begin bad++; $display("FAIL rm_resume_gnt1 got=%b exp=0", a.gnt1); end
    a.addr0 = 8'd131;
    tick();
    total++; if (a.rdata !== 8'h11) begin bad++; $display("FAIL rm_write_dropped got=%h exp=11", a.rdata); end
    a.req0 = 1'b0; a.req1 = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    a.req0 = 1'b0; a.req1 = 1'b0; a.we0 = 1'b0; a.we1 = 1'b0;
    a.addr0 = '0; a.addr1 = '0; a.din0 = '0; a.din1 = '0;
    b.req0 = 1'b0; b.req1 = 1'b0; b.we0 = 1'b0; b.we1 = 1'b0;
    b.addr0 = '0; b.addr1 = '0; b.din0 = '0; b.din1 = '0;
    test_reset();
    test_write_read();
    test_window1();
    test_round_robin();
    test_preempt();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
